modexp_arbiter: RTL and testbench

Round-robin scheduler that shares one `encrypt_decrypt` modular-exponentiation engine between `NREQ` requesters, such as the encrypt and decrypt channels and key-check logic. It accepts operand triples over a valid/ready handshake and screens out operands the engine cannot compute correctly. It then launches the engine, waits for its `finish`, and returns the result to the granted requester over a valid/ready response handshake. The block sits between the requester front-ends and the single engine instance; the engine is instantiated outside this block.

---
 rtl/modexp_arbiter_pkg.sv | 35 +++
 rtl/modexp_arbiter_if.sv | 29 ++
 rtl/modexp_arbiter_rr_pick.sv | 32 +++
 rtl/modexp_arbiter.sv | 109 ++++++++++
 tb/tb_modexp_arbiter.sv | 514 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/modexp_arbiter_pkg.sv
// Shared types and helpers for the modexp arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modexp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_WAIT    = 3'd4,
        ST_RESPOND = 3'd5
    } state_t;

    // Operand checks run at a fixed width; callers zero-extend into it.
    localparam int unsigned CHK_W = 64;

    // What the engine returns for exponent 0.
    localparam logic [CHK_W-1:0] EXP_ONE = 64'd1;

    function automatic int unsigned operand_width(input int unsigned word);
        return 2 * word;
    endfunction

    // The engine only handles a modulus that fits one word, is at least 2,
    // and exceeds the base.
    function automatic logic operand_reject(input logic [CHK_W-1:0] base,
                                            input logic [CHK_W-1:0] modulo,
                                            input int unsigned      word);
        logic hi_set;
        hi_set = (modulo >> word) != '0;
        return (modulo < 64'd2) || hi_set || (base >= modulo);
    endfunction

endpackage

// File: rtl/modexp_arbiter_if.sv
// Requester-side request/response bundle for the modexp arbiter.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both request and response directions.
interface modexp_arbiter_if #(
    parameter int WORDSIZE = 16,
    parameter int NREQ     = 4
);
    localparam int DW = 2 * WORDSIZE;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_base;
    logic [NREQ*DW-1:0] req_modulo;
    logic [NREQ*DW-1:0] req_exponent;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_result;
    logic               rsp_error;

    modport slave (
        input  req_valid, req_base, req_modulo, req_exponent, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_error
    );

    modport master (
        output req_valid, req_base, req_modulo, req_exponent, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_error
    );
endinterface

// File: rtl/modexp_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; grant is a pure function of req and ptr.
module rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx,
    output logic                    any
);
    localparam int IW = $clog2(NREQ);

    int idx;

    always_comb begin
        idx     = 0;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/modexp_arbiter.sv
// Shares one modexp engine among NREQ requesters, screening bad operands.
// Latency: reject -> rsp at T+2; accept -> rsp the cycle after finish in WAIT (>= T+5).
// Backpressure: one job in flight; no req_ready until the response is taken.
module modexp_arbiter
    import modexp_pkg::*;
#(
    parameter int WORDSIZE = 16,
    parameter int NREQ     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    modexp_arbiter_if.slave       bus,
    output logic                  busy,
    output logic [2*WORDSIZE-1:0] eng_base,
    output logic [2*WORDSIZE-1:0] eng_modulo,
    output logic [2*WORDSIZE-1:0] eng_exponent,
    output logic                  eng_start,
    input  logic                  eng_finish,
    input  logic [2*WORDSIZE-1:0] eng_result
);
    localparam int DW = operand_width(WORDSIZE);
    localparam int IW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt, gnt_q;
    logic [DW-1:0]   op_base, op_modulo, op_exponent, result_q;
    logic            err_q;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            xfer;
    logic            reject;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign xfer    = (state == ST_IDLE) && pick_any && !reset;
    assign reject  = operand_reject(CHK_W'(op_base), CHK_W'(op_modulo), WORDSIZE);
    assign ptr_nxt = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (xfer) state_nxt = ST_CHECK;
            ST_CHECK:   state_nxt = reject ? ST_RESPOND : ST_LAUNCH;
            ST_LAUNCH:  state_nxt = ST_SETTLE;
            // finish may still be high from the previous job here
            ST_SETTLE:  state_nxt = ST_WAIT;
            ST_WAIT:    if (eng_finish) state_nxt = ST_RESPOND;
            ST_RESPOND: if (bus.rsp_ready[gnt_q]) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            gnt_q        <= '0;
            op_base      <= '0;
            op_modulo    <= '0;
            op_exponent  <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
            eng_base     <= '0;
            eng_modulo   <= '0;
            eng_exponent <= '0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                gnt_q       <= pick_idx;
                ptr         <= ptr_nxt;
                op_base     <= bus.req_base[pick_idx*DW +: DW];
                op_modulo   <= bus.req_modulo[pick_idx*DW +: DW];
                op_exponent <= bus.req_exponent[pick_idx*DW +: DW];
            end
            // Engine operands only move on an accepted job so they stay
            // stable from LAUNCH until the next launch.
            if (state == ST_CHECK) begin
                err_q <= reject;
                if (reject) begin
                    result_q <= '0;
                end else begin
                    eng_base     <= op_base;
                    eng_modulo   <= op_modulo;
                    eng_exponent <= op_exponent;
                end
            end
            if (state == ST_WAIT && eng_finish) result_q <= eng_result;
        end
    end

    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        if (!reset && state == ST_IDLE)    bus.req_ready = pick_gnt;
        if (!reset && state == ST_RESPOND) bus.rsp_valid[gnt_q] = 1'b1;
    end

    assign bus.rsp_result = result_q;
    assign bus.rsp_error  = err_q;
    assign busy           = (state != ST_IDLE);
    assign eng_start      = reset | (state == ST_LAUNCH);
endmodule

// File: tb/tb_modexp_arbiter.sv
// Bench for modexp_arbiter with a behavioural engine and a response scoreboard.
// Engine model holds finish high until one cycle after its next start.
module tb_modexp_arbiter;
    import modexp_pkg::*;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int DW = 2 * W;

    typedef struct {
        logic [N-1:0]  vld;
        logic [DW-1:0] res;
        logic          err;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          busy, eng_start;
    logic          eng_finish = 1'b0;
    logic [DW-1:0] eng_base, eng_modulo, eng_exponent;
    logic [DW-1:0] eng_result = '0;

    int   cyc = 0;
    int   n_launch = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   eng_lat = 4;
    exp_t sb[$];

    modexp_arbiter_if #(.WORDSIZE(W), .NREQ(N)) bus ();

    modexp_arbiter #(.WORDSIZE(W), .NREQ(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .busy         (busy),
        .eng_base     (eng_base),
        .eng_modulo   (eng_modulo),
        .eng_exponent (eng_exponent),
        .eng_start    (eng_start),
        .eng_finish   (eng_finish),
        .eng_result   (eng_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (eng_start && !reset) n_launch++;
    end

    function automatic logic [DW-1:0] mexp(input logic [DW-1:0] b, input logic [DW-1:0] e,
                                           input logic [DW-1:0] m);
        longint unsigned r, bb, mm;
        mm = longint'(m);
        if (mm == 0) return '0;
        bb = longint'(b) % mm;
        r  = 1 % mm;
        for (int i = 0; i < DW; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return DW'(r);
    endfunction

    // Behavioural engine: synchronous reset on eng_start; finish lags start by one cycle.
    logic eng_run = 1'b0, eng_pend = 1'b0;
    int   eng_cnt = 0;
    always @(posedge clk) begin
        if (eng_start) begin
            eng_run  <= 1'b1;
            eng_cnt  <= eng_lat;
            eng_pend <= 1'b1;
        end else begin
            if (eng_pend) begin
                eng_finish <= 1'b0;
                eng_pend   <= 1'b0;
            end
            if (eng_run) begin
                if (eng_cnt == 0) begin
                    eng_finish <= 1'b1;
                    eng_result <= mexp(eng_base, eng_exponent, eng_modulo);
                    eng_run    <= 1'b0;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
        end
    end

    function automatic exp_t model(input int idx, input logic [DW-1:0] b,
                                   input logic [DW-1:0] e, input logic [DW-1:0] m);
        exp_t x;
        x.vld      = '0;
        x.vld[idx] = 1'b1;
        x.err      = (m < 2) || ((m >> W) != 0) || (b >= m);
        x.res      = x.err ? '0 : mexp(b, e, m);
        return x;
    endfunction

    task automatic set_op(input int idx, input logic [DW-1:0] b, input logic [DW-1:0] e,
                          input logic [DW-1:0] m);
        bus.req_base[idx*DW +: DW]     = b;
        bus.req_exponent[idx*DW +: DW] = e;
        bus.req_modulo[idx*DW +: DW]   = m;
    endtask

    task automatic push(input int idx);
        sb.push_back(model(idx, bus.req_base[idx*DW +: DW], bus.req_exponent[idx*DW +: DW],
                           bus.req_modulo[idx*DW +: DW]));
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns at the negedge after the transfer edge; t is the transfer cycle.
    task automatic wait_grant(output logic [N-1:0] g, output int t);
        g = '0;
        t = -1;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (bus.req_ready != '0) begin
                g = bus.req_ready;
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: no req_ready within 400 cycles, req_valid=%b", bus.req_valid);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output exp_t o, output exp_t e, output int t);
        t = -1;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (bus.rsp_valid != '0) begin
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (t < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_timeout: no rsp_valid within 400 cycles");
        end
        o.vld = bus.rsp_valid;
        o.res = bus.rsp_result;
        o.err = bus.rsp_error;
        e.vld = '0;
        e.res = '0;
        e.err = 1'b0;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: response vld=%b with no expected entry", o.vld);
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic ack(input int idx);
        bus.rsp_ready      = '0;
        bus.rsp_ready[idx] = 1'b1;
        @(negedge clk);
        bus.rsp_ready = '0;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (eng_start !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_eng_start: got %b want 1", eng_start);
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_error, busy, eng_start} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b vld=%b res=%0d err=%b busy=%b start=%b want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_error, busy, eng_start);
        end
        n_checks++;
        if ({eng_base, eng_modulo, eng_exponent} !== '0) begin
            n_fail++;
            $display("FAIL reset_eng_ops: base=%0d mod=%0d exp=%0d want 0", eng_base, eng_modulo, eng_exponent);
        end
    endtask

    task automatic test_basic();
        logic [N-1:0] g;
        int t, tr, l0;
        exp_t o, e;
        l0 = n_launch;
        set_op(0, 4, 13, 497);
        bus.req_valid[0] = 1'b1;
        wait_grant(g, t);
        bus.req_valid[0] = 1'b0;
        push(0);
        wait_rsp(o, e, tr);
        n_checks++;
        if ({o.vld, o.res, o.err} !== {4'b0001, 32'd445, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_rsp: vld=%b res=%0d err=%b want 0001/445/0", o.vld, o.res, o.err);
        end
        n_checks++;
        if ({o.vld, o.res, o.err} !== {e.vld, e.res, e.err}) begin
            n_fail++;
            $display("FAIL basic_model: res=%0d want %0d", o.res, e.res);
        end
        n_checks++;
        if (n_launch - l0 != 1) begin
            n_fail++;
            $display("FAIL basic_start_cycles: eng_start high %0d cycles want 1", n_launch - l0);
        end
        n_checks++;
        if (tr != t + 5 + eng_lat) begin
            n_fail++;
            $display("FAIL basic_latency: rsp at T+%0d want T+%0d", tr - t, 5 + eng_lat);
        end
        ack(0);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_after_ack: busy=%b want 0", busy);
        end
    endtask

    task automatic test_two_requesters();
        logic [N-1:0] g;
        int t, tr;
        exp_t o, e;
        do_reset();
        set_op(1, 5, 3, 17);
        set_op(3, 9, 7, 13);
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 2; k++) begin
            int want_idx;
            logic [N-1:0] want_g;
            want_idx         = (k == 0) ? 1 : 3;
            want_g           = '0;
            want_g[want_idx] = 1'b1;
            wait_grant(g, t);
            bus.req_valid[want_idx] = 1'b0;
            n_checks++;
            if (g !== want_g) begin
                n_fail++;
                $display("FAIL pair_grant%0d: got %b want %b", k, g, want_g);
            end
            push(want_idx);
            wait_rsp(o, e, tr);
            n_checks++;
            if ({o.vld, o.res, o.err} !== {e.vld, e.res, e.err}) begin
                n_fail++;
                $display("FAIL pair_rsp%0d: vld=%b res=%0d err=%b want %b/%0d/%b",
                         k, o.vld, o.res, o.err, e.vld, e.res, e.err);
            end
            ack(want_idx);
        end
    endtask

    task automatic test_all_four();
        logic [N-1:0] g, want_g;
        int t, tr;
        exp_t o, e;
        do_reset();
        set_op(0, 2, 5, 31);
        set_op(1, 3, 4, 101);
        set_op(2, 10, 3, 257);
        set_op(3, 6, 6, 1009);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            want_g        = '0;
            want_g[k % 4] = 1'b1;
            wait_grant(g, t);
            if (k == 4) bus.req_valid = '0;
            n_checks++;
            if (g !== want_g) begin
                n_fail++;
                $display("FAIL rotate_grant%0d: got %b want %b", k, g, want_g);
            end
            push(k % 4);
            wait_rsp(o, e, tr);
            n_checks++;
            if ({o.vld, o.res, o.err} !== {e.vld, e.res, e.err}) begin
                n_fail++;
                $display("FAIL rotate_rsp%0d: vld=%b res=%0d err=%b want %b/%0d/%b",
                         k, o.vld, o.res, o.err, e.vld, e.res, e.err);
            end
            ack(k % 4);
        end
    endtask

    task automatic test_reject();
        logic [DW-1:0] bases [3];
        logic [DW-1:0] mods  [3];
        logic [N-1:0] g;
        int t, tr, l0;
        exp_t o, e;
        bases = '{32'd0, 32'd2, 32'd500};
        mods  = '{32'd1, 32'h0001_0003, 32'd497};
        for (int k = 0; k < 3; k++) begin
            l0 = n_launch;
            set_op(2, bases[k], 5, mods[k]);
            bus.req_valid[2] = 1'b1;
            wait_grant(g, t);
            bus.req_valid[2] = 1'b0;
            push(2);
            wait_rsp(o, e, tr);
            n_checks++;
            if ({o.vld, o.res, o.err} !== {4'b0100, 32'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reject%0d_rsp: vld=%b res=%0d err=%b want 0100/0/1", k, o.vld, o.res, o.err);
            end
            n_checks++;
            if (tr != t + 2) begin
                n_fail++;
                $display("FAIL reject%0d_latency: rsp at T+%0d want T+2", k, tr - t);
            end
            n_checks++;
            if (n_launch != l0) begin
                n_fail++;
                $display("FAIL reject%0d_no_launch: eng_start cycles %0d want 0", k, n_launch - l0);
            end
            ack(2);
        end
    endtask

    task automatic test_exp_zero();
        logic [N-1:0] g;
        int t, tr;
        exp_t o, e;
        set_op(1, 4, 13, 497);
        bus.req_valid[1] = 1'b1;
        wait_grant(g, t);
        bus.req_valid[1] = 1'b0;
        push(1);
        wait_rsp(o, e, tr);
        ack(1);
        // finish and a stale result of 445 are still up when the next job launches
        eng_lat = 0;
        set_op(2, 7, 0, 11);
        bus.req_valid[2] = 1'b1;
        wait_grant(g, t);
        bus.req_valid[2] = 1'b0;
        push(2);
        wait_rsp(o, e, tr);
        n_checks++;
        if ({o.vld, o.res, o.err} !== {4'b0100, DW'(EXP_ONE), 1'b0}) begin
            n_fail++;
            $display("FAIL exp0_rsp: vld=%b res=%0d err=%b want 0100/1/0", o.vld, o.res, o.err);
        end
        n_checks++;
        if (tr != t + 5) begin
            n_fail++;
            $display("FAIL exp0_latency: rsp at T+%0d want T+5", tr - t);
        end
        ack(2);
        eng_lat = 4;
    endtask

    task automatic test_backpressure();
        logic [N-1:0] g;
        int t, tr, bad;
        exp_t o, e;
        do_reset();
        set_op(0, 3, 5, 7);
        bus.req_valid = 4'b0001;
        wait_grant(g, t);
        bus.req_valid = '0;
        push(0);
        set_op(1, 2, 10, 1000);
        set_op(2, 6, 2, 35);
        bus.req_valid = 4'b0110;
        wait_rsp(o, e, tr);
        n_checks++;
        if ({o.vld, o.res, o.err} !== {4'b0001, 32'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_rsp: vld=%b res=%0d err=%b want 0001/5/0", o.vld, o.res, o.err);
        end
        bus.rsp_ready = 4'b0110;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid !== 4'b0001 || bus.rsp_result !== e.res || bus.rsp_error !== e.err ||
                bus.req_ready !== '0 || busy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d of 50 cycles changed (vld=%b res=%0d rdy=%b) want 0",
                     bad, bus.rsp_valid, bus.rsp_result, bus.req_ready);
        end
        ack(0);
        for (int k = 1; k < 3; k++) begin
            logic [N-1:0] want_g;
            want_g    = '0;
            want_g[k] = 1'b1;
            wait_grant(g, t);
            bus.req_valid[k] = 1'b0;
            n_checks++;
            if (g !== want_g) begin
                n_fail++;
                $display("FAIL bp_next_grant%0d: got %b want %b", k, g, want_g);
            end
            push(k);
            wait_rsp(o, e, tr);
            n_checks++;
            if ({o.vld, o.res, o.err} !== {e.vld, e.res, e.err}) begin
                n_fail++;
                $display("FAIL bp_rsp%0d: vld=%b res=%0d err=%b want %b/%0d/%b",
                         k, o.vld, o.res, o.err, e.vld, e.res, e.err);
            end
            ack(k);
        end
    endtask

    task automatic test_reset_wait();
        logic [N-1:0] g;
        int t, tr;
        exp_t o, e;
        eng_lat = 30;
        set_op(1, 9, 4, 11);
        bus.req_valid[1] = 1'b1;
        wait_grant(g, t);
        bus.req_valid[1] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwait_busy: busy=%b want 1 in WAIT", busy);
        end
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_result, bus.rsp_error, busy, eng_base, eng_modulo,
             eng_exponent} !== '0 || eng_start !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwait_outputs: vld=%b res=%0d busy=%b base=%0d start=%b want zeros, start 1",
                     bus.rsp_valid, bus.rsp_result, busy, eng_base, eng_start);
        end
        reset   = 1'b0;
        eng_lat = 4;
        set_op(0, 3, 5, 7);
        set_op(2, 4, 13, 497);
        bus.req_valid = 4'b0101;
        wait_grant(g, t);
        bus.req_valid = '0;
        n_checks++;
        if (g !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstwait_ptr: grant %b want 0001", g);
        end
        push(0);
        wait_rsp(o, e, tr);
        n_checks++;
        if ({o.vld, o.res, o.err} !== {4'b0001, 32'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL rstwait_rsp: vld=%b res=%0d err=%b want 0001/5/0", o.vld, o.res, o.err);
        end
        ack(0);
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = '0;
        bus.rsp_ready    = '0;
        bus.req_base     = '0;
        bus.req_modulo   = '0;
        bus.req_exponent = '0;
        test_reset();
        test_basic();
        test_two_requesters();
        test_all_four();
        test_reject();
        test_exp_zero();
        test_backpressure();
        test_reset_wait();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
